// File: rtl/mem_access_unit_if.sv
// Request/response and Wishbone-classic signal bundle for mem_access_unit.
// Ports: pipeline request (req_valid, MemRead, MemWrite, MemSize, addr, wdata),
//        status (busy, done, err, rdata), Wishbone master (wb_*_o / wb_*_i).
// Modport master: the access unit itself; modport slave: the pipeline plus the bus.
interface mem_access_unit_if;
  // pipeline request side
  logic        req_valid;
  logic        MemRead;
  logic        MemWrite;
  logic        MemSize;
  logic [31:0] addr;
  logic [31:0] wdata;
  // pipeline response side
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // Wishbone classic master
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  req_valid, MemRead, MemWrite, MemSize, addr, wdata,
    output busy, done, err, rdata,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    output req_valid, MemRead, MemWrite, MemSize, addr, wdata,
    input  busy, done, err, rdata,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: one Wishbone-classic transaction per load/store request.
// Latency: request edge -> cyc next cycle; done one cycle after the ack edge (min 2).
// Backpressure: busy holds the pipeline; requests are sampled only while idle.
// Ports: clk, reset (async, active-high), bus (mem_access_unit_if.master).
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_access_unit_if.master      bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [9:0] TERM_CNT = 10'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;

  logic [9:0]  r_cnt;
  logic        r_err;
  logic        r_word;      // 1 = word access in flight, 0 = byte access
  logic [1:0]  r_lane;      // byte lane of a byte access
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rdata;

  logic        w_one_op;
  logic        w_both_op;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_reject;
  logic        w_ack_hit;
  logic        w_timeout;
  logic [7:0]  w_lane_byte;

  // Request decode, only meaningful in IDLE.
  assign w_one_op     = bus.MemRead ^ bus.MemWrite;
  assign w_both_op    = bus.MemRead & bus.MemWrite;
  assign w_misaligned = bus.MemSize & (bus.addr[1:0] != 2'b00);
  assign w_lane_byte  = bus.wb_dat_i[8*r_lane +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_ack_hit    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          // A request with neither op set is not a memory access at all.
          if (w_both_op || (w_one_op && w_misaligned)) begin
            w_reject     = 1'b1;
            w_next_state = S_RESP;
          end else if (w_one_op) begin
            w_accept     = 1'b1;
            w_next_state = S_BUS;
          end
        end
      end
      S_BUS: begin
        // Ack takes priority over the terminal count in the same cycle.
        if (bus.wb_ack_i) begin
          w_ack_hit    = 1'b1;
          w_next_state = S_RESP;
        end else if (r_cnt == TERM_CNT) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_word  <= 1'b0;
      r_lane  <= 2'b00;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
    end else begin
      // Counter is zero on every BUS entry and counts ack-less BUS cycles.
      if (r_state == S_BUS && !bus.wb_ack_i) begin
        r_cnt <= r_cnt + 10'd1;
      end else begin
        r_cnt <= '0;
      end

      if (w_accept) begin
        r_err  <= 1'b0;
        r_word <= bus.MemSize;
        r_lane <= bus.addr[1:0];
        r_we   <= bus.MemWrite;
        r_adr  <= {bus.addr[31:2], 2'b00};
        if (bus.MemSize) begin
          r_sel <= 4'b1111;
          r_dat <= bus.wdata;
        end else begin
          r_sel <= 4'b0001 << bus.addr[1:0];
          r_dat <= {4{bus.wdata[7:0]}};
        end
      end

      if (w_reject || w_timeout) begin
        r_err <= 1'b1;
      end

      // Stores leave rdata untouched; loads capture on ack.
      if (w_ack_hit && !r_we) begin
        if (r_word) begin
          r_rdata <= bus.wb_dat_i;
        end else begin
          r_rdata <= {{24{w_lane_byte[7]}}, w_lane_byte};
        end
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_RESP);
  assign bus.err      = (r_state == S_RESP) & r_err;
  assign bus.rdata    = r_rdata;
  assign bus.wb_cyc_o = (r_state == S_BUS);
  assign bus.wb_stb_o = (r_state == S_BUS);
  assign bus.wb_we_o  = r_we;
  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat;
  assign bus.wb_sel_o = r_sel;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs sampled there too.
// TIMEOUT is set to 4 so the timeout path is short.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mem_access_unit_if bus_if();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request before the next edge (edge 0); returns in cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic sz,
                       input logic [31:0] a, input logic [31:0] d);
    bus_if.req_valid = 1'b1;
    bus_if.MemRead   = rd;
    bus_if.MemWrite  = wr;
    bus_if.MemSize   = sz;
    bus_if.addr      = a;
    bus_if.wdata     = d;
    step();
    bus_if.req_valid = 1'b0;
    bus_if.MemRead   = 1'b0;
    bus_if.MemWrite  = 1'b0;
  endtask

  // Called in the cycle the ack should be presented; returns in the done cycle.
  task automatic ack_now(input logic [31:0] d);
    bus_if.wb_ack_i = 1'b1;
    bus_if.wb_dat_i = d;
    step();
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_dat_i = 32'h0;
  endtask

  initial begin
    int cyc_cnt;
    logic seen_done;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.MemRead   = 1'b0;
    bus_if.MemWrite  = 1'b0;
    bus_if.MemSize   = 1'b0;
    bus_if.addr      = 32'h0;
    bus_if.wdata     = 32'h0;
    bus_if.wb_dat_i  = 32'h0;
    bus_if.wb_ack_i  = 1'b0;

    #1;
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_err", bus_if.err, 0);
    chk("rst_rdata", bus_if.rdata, 0);
    chk("rst_cyc", bus_if.wb_cyc_o, 0);
    chk("rst_stb", bus_if.wb_stb_o, 0);
    chk("rst_we", bus_if.wb_we_o, 0);
    chk("rst_adr", bus_if.wb_adr_o, 0);
    chk("rst_dat", bus_if.wb_dat_o, 0);
    chk("rst_sel", bus_if.wb_sel_o, 0);
    step();
    reset = 1'b0;
    step();

    // Stray ack while idle must not start anything.
    bus_if.wb_ack_i = 1'b1;
    step();
    bus_if.wb_ack_i = 1'b0;
    chk("idle_ack_busy", bus_if.busy, 0);

    // Request with neither op set is ignored.
    issue(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0);
    chk("noop_busy", bus_if.busy, 0);
    chk("noop_cyc", bus_if.wb_cyc_o, 0);

    // Word load, ack in cycle 3, done in cycle 4.
    issue(1'b1, 1'b0, 1'b1, 32'h0000_1004, 32'h0);
    chk("wl_cyc", bus_if.wb_cyc_o, 1);
    chk("wl_stb", bus_if.wb_stb_o, 1);
    chk("wl_busy", bus_if.busy, 1);
    chk("wl_adr", bus_if.wb_adr_o, 32'h0000_1004);
    chk("wl_sel", bus_if.wb_sel_o, 4'b1111);
    chk("wl_we", bus_if.wb_we_o, 0);
    step();
    chk("wl_c2_done", bus_if.done, 0);
    step();
    ack_now(32'hDEAD_BEEF);
    chk("wl_done", bus_if.done, 1);
    chk("wl_err", bus_if.err, 0);
    chk("wl_rdata", bus_if.rdata, 32'hDEAD_BEEF);
    chk("wl_cyc_drop", bus_if.wb_cyc_o, 0);
    step();
    chk("wl_done_pulse", bus_if.done, 0);
    chk("wl_idle", bus_if.busy, 0);

    // Byte load, lane 3, negative.
    issue(1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h0);
    chk("bl_sel", bus_if.wb_sel_o, 4'b1000);
    chk("bl_adr", bus_if.wb_adr_o, 32'h0000_2000);
    ack_now(32'h8000_0000);
    chk("bl_done", bus_if.done, 1);
    chk("bl_rdata_neg", bus_if.rdata, 32'hFFFF_FF80);
    step();

    // Byte load, lane 3, positive.
    issue(1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h0);
    ack_now(32'h7F00_0000);
    chk("bl_rdata_pos", bus_if.rdata, 32'h0000_007F);
    step();

    // Byte store, lane 1.
    issue(1'b0, 1'b1, 1'b0, 32'h0000_3001, 32'h1234_56AB);
    chk("bs_we", bus_if.wb_we_o, 1);
    chk("bs_sel", bus_if.wb_sel_o, 4'b0010);
    chk("bs_dat", bus_if.wb_dat_o, 32'hABAB_ABAB);
    chk("bs_adr", bus_if.wb_adr_o, 32'h0000_3000);
    ack_now(32'hFFFF_FFFF);
    chk("bs_done", bus_if.done, 1);
    chk("bs_err", bus_if.err, 0);
    chk("bs_rdata_hold", bus_if.rdata, 32'h0000_007F);
    step();

    // Misaligned word store: error in cycle 1, no bus cycle.
    issue(1'b0, 1'b1, 1'b1, 32'h0000_4002, 32'h0);
    chk("mis_done", bus_if.done, 1);
    chk("mis_err", bus_if.err, 1);
    chk("mis_cyc", bus_if.wb_cyc_o, 0);
    step();
    chk("mis_cyc2", bus_if.wb_cyc_o, 0);
    chk("mis_idle", bus_if.busy, 0);

    // Both read and write set: same error response.
    issue(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0);
    chk("both_done", bus_if.done, 1);
    chk("both_err", bus_if.err, 1);
    chk("both_cyc", bus_if.wb_cyc_o, 0);
    chk("both_rdata_hold", bus_if.rdata, 32'h0000_007F);
    step();

    // Timeout with no ack: cyc high exactly 4 cycles, then done+err.
    issue(1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0);
    cyc_cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.wb_cyc_o) cyc_cnt++;
      if (bus_if.done) begin
        seen_done = 1'b1;
        break;
      end
      step();
    end
    chk("to_seen_done", seen_done, 1);
    chk("to_cyc_cycles", cyc_cnt, 4);
    chk("to_err", bus_if.err, 1);
    step();

    // Ack on the 4th (terminal) cycle wins.
    issue(1'b1, 1'b0, 1'b1, 32'h0000_5004, 32'h0);
    step();
    step();
    step();
    chk("to4_cyc", bus_if.wb_cyc_o, 1);
    ack_now(32'h55AA_1234);
    chk("to4_done", bus_if.done, 1);
    chk("to4_err", bus_if.err, 0);
    chk("to4_rdata", bus_if.rdata, 32'h55AA_1234);
    step();

    // Reset during cycle 2 of a load clears everything at once.
    issue(1'b1, 1'b0, 1'b1, 32'h0000_6000, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("rmid_cyc", bus_if.wb_cyc_o, 0);
    chk("rmid_busy", bus_if.busy, 0);
    chk("rmid_done", bus_if.done, 0);
    chk("rmid_adr", bus_if.wb_adr_o, 0);
    chk("rmid_rdata", bus_if.rdata, 0);
    step();
    reset = 1'b0;
    step();
    chk("rpost_done", bus_if.done, 0);

    // Normal word load after reset.
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    chk("rnew_adr", bus_if.wb_adr_o, 32'h0000_0010);
    step();
    ack_now(32'hCAFE_F00D);
    chk("rnew_done", bus_if.done, 1);
    chk("rnew_err", bus_if.err, 0);
    chk("rnew_rdata", bus_if.rdata, 32'hCAFE_F00D);
    step();
    chk("rnew_idle", bus_if.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
